// File: rtl/i2s_tdm_tx.sv
// TDM/I2S serial transmitter: NUM_CH slots of SLOT_W bits, externally clocked by sck/ws,
// with a one-frame staging buffer. Define UNDERRUN_CNT_EN to build the saturating underrun counter.
module i2s_tdm_tx #(
  parameter int AUDIO_DW      = 8,
  parameter int NUM_CH        = 2,
  parameter int SLOT_W        = 16,
  parameter int UNDERRUN_ZERO = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         sck_i,
  input  logic                         ws_i,
  output logic                         sd_o,
  input  logic [AUDIO_DW*NUM_CH-1:0]   sample_i,
  input  logic                         sample_valid_i,
  output logic                         sample_ready_o,
  output logic                         frame_start_o,
  output logic                         underrun_o,
  output logic                         frame_short_o,
  output logic [7:0]                   underrun_cnt_o
);

  localparam int FW = AUDIO_DW * NUM_CH;
  localparam int SW = $clog2(NUM_CH + 1);
  localparam int BW = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
  localparam logic [SW-1:0] SLOT_END = SW'(NUM_CH);
  localparam logic [BW-1:0] BIT_LAST = BW'(SLOT_W - 1);

  // [0] and [1] are the synchroniser stages, [2] is the edge-detect history
  logic [2:0]    sck_sync_reg;
  logic [2:0]    ws_sync_reg;
  logic          sck_rise_reg;
  logic          sck_fall_reg;

  logic          ws_prev_reg, ws_prev_next;
  logic [SW-1:0] slot_reg, slot_next;
  logic [BW-1:0] bit_reg, bit_next;
  logic [FW-1:0] staging_reg, staging_next;
  logic          staging_full_reg, staging_full_next;
  logic [FW-1:0] active_reg, active_next;
  logic          sd_reg, sd_next;
  logic          frame_start_reg, frame_start_next;
  logic          underrun_reg, underrun_next;
  logic          frame_short_reg, frame_short_next;

  logic          frame_start_det;
  logic [FW-1:0] bit_hit;
  logic          tx_bit;

  // ws_sync_reg[2] is the ws value captured alongside the sck sample that raised sck_rise_reg
  assign frame_start_det = sck_rise_reg && ws_prev_reg && !ws_sync_reg[2];

  // One-hot bit selection: each active bit fires only at its own slot and MSB-first position
  genvar gi;
  generate
    for (gi = 0; gi < FW; gi++) begin : g_bit
      localparam int CH  = gi / AUDIO_DW;
      localparam int POS = AUDIO_DW - 1 - (gi % AUDIO_DW);
      assign bit_hit[gi] = active_reg[gi] && (slot_reg == SW'(CH)) && (bit_reg == BW'(POS));
    end
  endgenerate

  assign tx_bit = |bit_hit;

  always_comb begin
    ws_prev_next      = ws_prev_reg;
    slot_next         = slot_reg;
    bit_next          = bit_reg;
    staging_next      = staging_reg;
    staging_full_next = staging_full_reg;
    active_next       = active_reg;
    sd_next           = sd_reg;
    frame_start_next  = 1'b0;
    underrun_next     = 1'b0;
    frame_short_next  = 1'b0;

    if (sck_rise_reg) begin
      ws_prev_next = ws_sync_reg[2];
    end

    if (frame_start_det) begin
      slot_next        = '0;
      bit_next         = '0;
      frame_start_next = 1'b1;
      frame_short_next = (slot_reg != SLOT_END);
      if (staging_full_reg) begin
        active_next       = staging_reg;
        staging_full_next = 1'b0;
      end else if (sample_valid_i) begin
        // Late sample bypasses staging so it still makes this frame
        active_next = sample_i;
      end else begin
        underrun_next = 1'b1;
        if (UNDERRUN_ZERO != 0) begin
          active_next = '0;
        end
      end
    end else if (sample_valid_i && !staging_full_reg) begin
      staging_next      = sample_i;
      staging_full_next = 1'b1;
    end

    if (sck_fall_reg) begin
      sd_next = tx_bit;
      if (slot_reg != SLOT_END) begin
        if (bit_reg == BIT_LAST) begin
          bit_next  = '0;
          slot_next = slot_reg + SW'(1);
        end else begin
          bit_next = bit_reg + BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_sync_reg     <= '0;
      ws_sync_reg      <= '0;
      sck_rise_reg     <= 1'b0;
      sck_fall_reg     <= 1'b0;
      ws_prev_reg      <= 1'b0;
      slot_reg         <= SLOT_END;
      bit_reg          <= '0;
      staging_reg      <= '0;
      staging_full_reg <= 1'b0;
      active_reg       <= '0;
      sd_reg           <= 1'b0;
      frame_start_reg  <= 1'b0;
      underrun_reg     <= 1'b0;
      frame_short_reg  <= 1'b0;
    end else begin
      sck_sync_reg     <= {sck_sync_reg[1:0], sck_i};
      ws_sync_reg      <= {ws_sync_reg[1:0], ws_i};
      sck_rise_reg     <= sck_sync_reg[1] && !sck_sync_reg[2];
      sck_fall_reg     <= !sck_sync_reg[1] && sck_sync_reg[2];
      ws_prev_reg      <= ws_prev_next;
      slot_reg         <= slot_next;
      bit_reg          <= bit_next;
      staging_reg      <= staging_next;
      staging_full_reg <= staging_full_next;
      active_reg       <= active_next;
      sd_reg           <= sd_next;
      frame_start_reg  <= frame_start_next;
      underrun_reg     <= underrun_next;
      frame_short_reg  <= frame_short_next;
    end
  end

  assign sd_o           = sd_reg;
  assign sample_ready_o = !staging_full_reg;
  assign frame_start_o  = frame_start_reg;
  assign underrun_o     = underrun_reg;
  assign frame_short_o  = frame_short_reg;

`ifdef UNDERRUN_CNT_EN
  logic [7:0] underrun_cnt_reg, underrun_cnt_next;

  always_comb begin
    underrun_cnt_next = underrun_cnt_reg;
    if (underrun_reg && (underrun_cnt_reg != 8'hFF)) begin
      underrun_cnt_next = underrun_cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      underrun_cnt_reg <= 8'h00;
    end else begin
      underrun_cnt_reg <= underrun_cnt_next;
    end
  end

  assign underrun_cnt_o = underrun_cnt_reg;
`else
  assign underrun_cnt_o = 8'h00;
`endif

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Directed bench: a 2ch/16-bit-slot repeat-on-underrun instance and a 4ch/8-bit-slot
// zero-on-underrun instance share sck/ws; serial output is collected per sck cycle.
module tb_i2s_tdm_tx;

  logic        clk = 1'b0;
  logic        rst, sck, ws;
  logic [15:0] sample;
  logic        valid;
  logic [31:0] sample4;
  logic        valid4;
  logic        sd, ready, fs, ur, short;
  logic [7:0]  cnt;
  logic        sd4, ready4, fs4, ur4, short4;
  logic [7:0]  cnt4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fs_n = 0, ur_n = 0, ur4_n = 0, short_n = 0, short4_n = 0, ur_since = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fs)     fs_n++;
    if (ur)     begin ur_n++; ur_since++; end
    if (ur4)    ur4_n++;
    if (short)  short_n++;
    if (short4) short4_n++;
  end

  i2s_tdm_tx #(.AUDIO_DW(8), .NUM_CH(2), .SLOT_W(16), .UNDERRUN_ZERO(0)) u_dut (
    .clk_i(clk), .rst_i(rst), .sck_i(sck), .ws_i(ws), .sd_o(sd),
    .sample_i(sample), .sample_valid_i(valid), .sample_ready_o(ready),
    .frame_start_o(fs), .underrun_o(ur), .frame_short_o(short), .underrun_cnt_o(cnt));

  i2s_tdm_tx #(.AUDIO_DW(8), .NUM_CH(4), .SLOT_W(8), .UNDERRUN_ZERO(1)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .sck_i(sck), .ws_i(ws), .sd_o(sd4),
    .sample_i(sample4), .sample_valid_i(valid4), .sample_ready_o(ready4),
    .frame_start_o(fs4), .underrun_o(ur4), .frame_short_o(short4), .underrun_cnt_o(cnt4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One sck period (5 clk low, 5 clk high); call at a negedge of clk
  task automatic sck_cycle(input logic w);
    sck = 1'b0; ws = w;
    repeat (5) @(negedge clk);
    sck = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic send(input logic [15:0] d, input logic [31:0] d4);
    int n;
    n = 0;
    sample = d; sample4 = d4; valid = 1'b1; valid4 = 1'b1;
    while (!(ready && ready4) && n < 100) begin
      @(negedge clk); n++;
    end
    chk("send_timeout", (n < 100), 1);
    @(posedge clk); #1;
    valid = 1'b0; valid4 = 1'b0;
    chk("ready_low_after_accept", ready, 0);
    chk("ready4_low_after_accept", ready4, 0);
    @(negedge clk);
  endtask

  // n sck cycles with I2S-style ws (leads by one bit); the ws fall on the last
  // cycle starts the next frame. rx[31-i] is the bit driven on sck cycle i.
  task automatic frame(input int n, input bit late, input int rst_at,
                       input logic [15:0] ld, input logic [31:0] ld4,
                       output logic [31:0] rx, output logic [31:0] rx4);
    rx = '0; rx4 = '0;
    for (int i = 0; i < n; i++) begin
      sck = 1'b0;
      ws  = (i >= n/2 - 1) && (i < n - 1);
      if (i == rst_at) begin
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_sd", sd, 0);
        chk("rst_ready", ready, 1);
        chk("rst_sd4", sd4, 0);
        @(negedge clk);
        rst = 1'b0; ur_since = 0;
        repeat (2) @(negedge clk);
      end else begin
        repeat (5) @(negedge clk);
      end
      rx[31-i] = sd; rx4[31-i] = sd4;
      sck = 1'b1;
      if (late && i == n - 1) begin
        // valid only in the cycle whose edge consumes the rise strobe
        repeat (3) @(posedge clk);
        @(negedge clk);
        sample = ld; sample4 = ld4; valid = 1'b1; valid4 = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0; valid4 = 1'b0;
        chk("late_ready_stays_1", ready, 1);
        chk("late_ready4_stays_1", ready4, 1);
        repeat (2) @(negedge clk);
      end else begin
        repeat (5) @(negedge clk);
      end
    end
  endtask

  initial begin
    logic [31:0] rx, rx4;
    int hn, fs_at, acc_at;

    rst = 1'b1; sck = 1'b0; ws = 1'b1;
    sample = '0; valid = 1'b0; sample4 = '0; valid4 = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_sd", sd, 0);
    chk("reset_ready", ready, 1);
    chk("reset_pulses", {fs, ur, short}, 0);
    chk("reset_cnt", cnt, 0);
    chk("reset_ready4", ready4, 1);
    rst = 1'b0;
    @(negedge clk);

    // A into staging, then preamble ws 1,1,0 starts the first frame
    send(16'hA53C, 32'h8142FF3C);
    sck_cycle(1'b1); sck_cycle(1'b1); sck_cycle(1'b0);
    chk("pre_fs_count", fs_n, 1);
    chk("pre_no_underrun", ur_n, 0);
    chk("pre_ready_back", ready, 1);
    chk("pre_sd_idle", sd, 0);

    frame(32, 0, -1, '0, '0, rx, rx4);
    chk("t1_data", rx, 32'h3C00A500);
    chk("t1_data4", rx4, 32'h3CFF4281);
    chk("t1_underrun", ur_n, 1);
    chk("t1_underrun4", ur4_n, 1);
    chk("t1_not_short", short_n, 0);
    chk("t1_fs_count", fs_n, 2);

    // Underrun frame; B arrives exactly in the next frame-start cycle
    frame(32, 1, -1, 16'h0FF0, 32'h01807EE7, rx, rx4);
    chk("t2_repeat", rx, 32'h3C00A500);
    chk("t2_zero4", rx4, 32'h00000000);
    chk("t2_late_no_underrun", ur_n, 1);

    send(16'h6699, 32'h12345678);
    fork
      frame(32, 0, -1, '0, '0, rx, rx4);
      begin
        sample = 16'hC381; sample4 = 32'hF00FAA55; valid = 1'b1; valid4 = 1'b1;
        fs_at = -1; hn = 0;
        while (hn < 1000) begin
          @(negedge clk); hn++;
          if (fs) fs_at = cyc;
          if (ready && ready4) break;
        end
        @(posedge clk); #1;
        acc_at = cyc;
        valid = 1'b0; valid4 = 1'b0;
        chk("accept_after_fs", acc_at, fs_at + 1);
        chk("ready_low_d", ready, 0);
      end
    join
    chk("t3_late_data", rx, 32'hF0000F00);
    chk("t3_late_data4", rx4, 32'hE77E8001);
    chk("t3_no_underrun", ur_n, 1);

    frame(32, 0, -1, '0, '0, rx, rx4);
    chk("t4_data", rx, 32'h99006600);
    chk("t4_data4", rx4, 32'h78563412);
    chk("t4_no_underrun", ur_n, 1);

    frame(32, 0, -1, '0, '0, rx, rx4);
    chk("t5_data", rx, 32'h8100C300);
    chk("t5_data4", rx4, 32'h55AA0FF0);
    chk("t5_underrun", ur_n, 2);

    // 20-sck frame restarts early
    send(16'h5AF1, 32'h00C00300);
    frame(20, 0, -1, '0, '0, rx, rx4);
    chk("short_partial", rx, 32'h8100C000);
    chk("short_partial4", rx4, 32'h00000000);
    chk("short_pulse", short_n, 1);
    chk("short_pulse4", short4_n, 1);

    frame(32, 0, -1, '0, '0, rx, rx4);
    chk("t6_after_short", rx, 32'hF1005A00);
    chk("t6_after_short4", rx4, 32'h0003C000);

    // Reset in the middle of slot 0, with a frame waiting in staging
    send(16'h1234, 32'h89ABCDEF);
    frame(32, 0, 5, '0, '0, rx, rx4);
    chk("t7_before_rst", rx & 32'hF8000000, 32'hF0000000);
    chk("t7_silent_after_rst", rx & 32'h07FFFFFF, 32'h00000000);
    chk("t7_silent4", rx4, 32'h00000000);
    chk("t7_underrun_after_rst", ur_since, 1);

    frame(32, 0, -1, '0, '0, rx, rx4);
    chk("t8_zero_after_rst", rx, 32'h00000000);
    chk("t8_zero4_after_rst", rx4, 32'h00000000);

    // 300 back-to-back two-bit frames, all underruns
    for (int k = 0; k < 300; k++) begin
      sck_cycle(1'b1);
      sck_cycle(1'b0);
    end
    repeat (3) @(negedge clk);
    chk("burst_underruns", ur_since, 302);
`ifdef UNDERRUN_CNT_EN
    chk("cnt_saturated", cnt, 8'd255);
    chk("cnt4_saturated", cnt4, 8'd255);
`else
    chk("cnt_tied_off", cnt, 8'd0);
    chk("cnt4_tied_off", cnt4, 8'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_tdm_tx.md
# i2s_tdm_tx

Parametrised successor to the two-channel I2S transmitter. Serialises NUM_CH channels of AUDIO_DW-bit audio into SLOT_W-bit TDM slots, with sck/ws from an external bit-clock master oversampled in the system clock domain. A staging buffer with a valid/ready handshake feeds samples in, and an underrun policy covers late samples. The block sits between the sample sources (KS string, PRBS noise) and the uio pads, and replaces the ad-hoc load-pulse registers in the top level.

## Interface
- AUDIO_DW, 8, sample width per channel
- NUM_CH, 2, channels per frame (1..8)
- SLOT_W, 16, sck cycles per slot (>= AUDIO_DW)
- UNDERRUN_ZERO, 0, on underrun: 1 = transmit zeros, 0 = repeat last frame
- clk_i  in  1  system clock; all logic on posedge
- rst_i  in  1  synchronous, active-high reset
- sck_i  in  1  external bit clock, asynchronous
- ws_i  in  1  external word select, asynchronous
- sd_o  out  1  serial data, registered
- sample_i  in  AUDIO_DW*NUM_CH  packed samples, channel 0 in LSBs
- sample_valid_i  in  1  sample_i holds a full frame
- sample_ready_o  out  1  staging buffer empty
- frame_start_o  out  1  one-cycle pulse on each detected frame start
- underrun_o  out  1  one-cycle pulse when a frame starts with no new data
- frame_short_o  out  1  one-cycle pulse when a frame restarts before NUM_CH*SLOT_W bits
- underrun_cnt_o  out  8  saturating underrun count (see Configuration)

## Operation
- sck_i and ws_i pass through 2-FF synchronisers, then one edge-detect register per signal, giving sck_rise and sck_fall strobes.
- ws is sampled on sck_rise. Sampled 1 then 0 marks a frame start, and the bit position counter p is set to 0.
- Each sck_fall updates sd_o, then increments p, saturating at NUM_CH*SLOT_W.
- Slot index is p / SLOT_W; bit index within the slot is p % SLOT_W.
- Within a slot, bits 0..AUDIO_DW-1 carry the channel sample MSB-first. Remaining slot bits transmit 0.
- Slot index >= NUM_CH transmits 0.
- Frame start handling (I2S one-bit delay falls out naturally: MSB goes on the first sck_fall after the ws falling edge's following sck_rise):
  - Staging full: staging moves to the active frame, staging empties.
  - Staging empty and sample_valid_i high in the same cycle: sample_i loads directly into active, staging stays empty, no underrun.
  - Staging empty and no valid: underrun_o pulses; active becomes zeros (UNDERRUN_ZERO=1) or is retained (UNDERRUN_ZERO=0).
- Handshake:
  - sample_ready_o = !staging_full. It has no combinational path from sample_valid_i.
  - An accept (valid & ready) fills staging.
  - sample_i must be held stable while valid && !ready.
- Early frame start (p < NUM_CH*SLOT_W at the new frame start) pulses frame_short_o; the new frame proceeds normally.
- Reset values:
  - sd_o=0; sample_ready_o=1; all pulses 0; underrun_cnt_o=0.
  - Staging empty, active zeroed, p saturated.
  - Synchroniser and edge registers cleared.
  - With p saturated, sd_o=0 until the first frame start.

## Timing
- Required ratio: clk_i >= 8x sck_i. sck high and low phases each >= 3 clk_i periods.
- Pad edge to strobe: 3 clk_i cycles (2 sync + 1 edge).
- sd_o changes 1 clk_i cycle after the sck_fall strobe, i.e. 4 clk_i cycles after the pad falling edge.
- frame_start_o and underrun_o assert in the cycle after the sck_rise strobe that detects the frame start.
- Accept-to-ready-low latency: 1 cycle. Frame-start-to-ready-high latency: 1 cycle.
- Reset mid-frame: within 1 cycle, sd_o=0 and all state returns to reset values. The block resumes at the next frame start.

## Configuration
- UNDERRUN_CNT_EN defined: 8-bit underrun counter. Increments on each underrun_o, saturates at 255, cleared only by rst_i.
- UNDERRUN_CNT_EN undefined: no counter logic; underrun_cnt_o tied to 8'h00.

## Test plan
- NUM_CH=2, SLOT_W=16, AUDIO_DW=8; load {8'hA5, 8'h3C}; run one 32-sck frame -> sd_o shows 0011_1100 + 8 zeros, then 1010_0101 + 8 zeros, MSB on the first sck_fall after the frame start.
- Accept a frame, then hold valid with a second frame -> sample_ready_o goes 0 one cycle after the accept; the second accept occurs one cycle after frame start; no underrun.
- No valid before frame start, UNDERRUN_ZERO=0 -> underrun_o pulses and the previous frame repeats. With UNDERRUN_ZERO=1, the frame is all zeros. With UNDERRUN_CNT_EN, 300 underruns -> underrun_cnt_o=255.
- sample_valid_i first asserted in the frame-start cycle with staging empty -> data transmitted in that frame, no underrun_o, sample_ready_o stays 1.
- ws falling edge after 20 sck of a 32-sck frame -> frame_short_o pulses and the new frame starts at MSB. NUM_CH=4, SLOT_W=8 -> four 8-bit slots, all bits past 32 are 0.
- rst_i asserted mid-slot -> sd_o=0 and sample_ready_o=1 next cycle; no output until the next ws falling edge.
